// File: rtl/eca_stepper_param.sv
// Elementary cellular automaton stepper: applies a run-time 8-bit rule to a
// WIDTH-cell register and streams each generation over a valid/ready port.
module eca_stepper_param #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned CNT_W         = 8,
    parameter bit          WRAP          = 1'b1,
    parameter bit          STOP_ON_FIXED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [7:0]       cfg_rule,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic [CNT_W-1:0] cfg_gens,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_state,
    output logic [CNT_W-1:0] out_gen,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        EMIT
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] cells_q;
    logic [WIDTH-1:0] next_cells;
    logic [7:0]       rule_q;
    logic [CNT_W-1:0] gens_q;
    logic [CNT_W-1:0] gen_q;
    logic             accept;
    logic             xfer;
    logic             last_word;

    // Pad the register with its boundary neighbours so every cell sees a
    // uniform 3-bit window: ext[i+2:i] = {left, centre, right} of cell i.
    logic [WIDTH+1:0] ext;
    logic             left_edge;
    logic             right_edge;

    assign left_edge  = WRAP ? cells_q[0]       : 1'b0;
    assign right_edge = WRAP ? cells_q[WIDTH-1] : 1'b0;
    assign ext        = {left_edge, cells_q, right_edge};

    // rule[7-idx] is the same bit as rule[~idx] for a 3-bit index.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign next_cells[i] = rule_q[~ext[i +: 3]];
    end

    assign last_word = (gen_q == gens_q) || (STOP_ON_FIXED && (next_cells == cells_q));
    assign accept    = (fsm_q == IDLE) && cfg_valid;
    assign xfer      = (fsm_q == EMIT) && out_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:    if (accept) fsm_d = EMIT;
            EMIT:    if (xfer && last_word) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from values sampled at the same edge.
        if (reset) begin
            // NOTE: the cell register is cleared too, because out_state
            // is read straight from it and must show 0 after reset.
            fsm_q   <= IDLE;
            cells_q <= '0;
            rule_q  <= '0;
            gens_q  <= '0;
            gen_q   <= '0;
        end else begin
            fsm_q <= fsm_d;
            if (accept) begin
                rule_q  <= cfg_rule;
                cells_q <= cfg_seed;
                gens_q  <= cfg_gens;
                gen_q   <= '0;
            end else if (xfer && !last_word) begin
                cells_q <= next_cells;
                gen_q   <= gen_q + CNT_W'(1);
            end
        end
    end

    // Outputs decode only registered state, so they hold while out_ready=0.
    assign cfg_ready = (fsm_q == IDLE);
    assign out_valid = (fsm_q == EMIT);
    assign busy      = (fsm_q == EMIT);
    assign out_last  = (fsm_q == EMIT) && last_word;
    assign out_state = cells_q;
    assign out_gen   = gen_q;

endmodule

// File: tb/tb_eca_stepper_param.sv
// Bench for eca_stepper_param: three instances covering the WRAP/STOP_ON_FIXED
// variants, driven with shared config and checked against a behavioural model.
module tb_eca_stepper_param;

    localparam int NI = 3;
    localparam bit WRAP_P [NI] = '{1'b1, 1'b1, 1'b0};
    localparam bit FIX_P  [NI] = '{1'b1, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic [7:0] cfg_rule;
    logic [7:0] cfg_seed;
    logic [7:0] cfg_gens;
    logic       out_ready;

    logic       cfg_ready [NI];
    logic       out_valid [NI];
    logic       out_last  [NI];
    logic       busy      [NI];
    logic [7:0] out_state [NI];
    logic [7:0] out_gen   [NI];

    int total = 0;
    int bad   = 0;

    logic [7:0] exps [NI][0:255];
    int         nexp [NI];
    int         got_n [NI];
    logic [7:0] got_fin [NI];

    always #5 clk = ~clk;

    eca_stepper_param #(.WIDTH(8), .CNT_W(8), .WRAP(1'b1), .STOP_ON_FIXED(1'b1)) d0 (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[0]),
        .cfg_rule(cfg_rule), .cfg_seed(cfg_seed), .cfg_gens(cfg_gens),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_state(out_state[0]),
        .out_gen(out_gen[0]), .out_last(out_last[0]), .busy(busy[0]));

    eca_stepper_param #(.WIDTH(8), .CNT_W(8), .WRAP(1'b1), .STOP_ON_FIXED(1'b0)) d1 (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[1]),
        .cfg_rule(cfg_rule), .cfg_seed(cfg_seed), .cfg_gens(cfg_gens),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_state(out_state[1]),
        .out_gen(out_gen[1]), .out_last(out_last[1]), .busy(busy[1]));

    eca_stepper_param #(.WIDTH(8), .CNT_W(8), .WRAP(1'b0), .STOP_ON_FIXED(1'b1)) d2 (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[2]),
        .cfg_rule(cfg_rule), .cfg_seed(cfg_seed), .cfg_gens(cfg_gens),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_state(out_state[2]),
        .out_gen(out_gen[2]), .out_last(out_last[2]), .busy(busy[2]));

    typedef struct {
        logic [7:0] rule;
        logic [7:0] seed;
        logic [7:0] gens;
        int         n   [NI];
        logic [7:0] fin [NI];
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Successor state from the rule definition: pattern value 4l+2c+r selects
    // rule bit (7 - pattern); out-of-range neighbours wrap or read 0.
    function automatic logic [7:0] model_next(input logic [7:0] s, input logic [7:0] rule, input bit wrap);
        int v = int'(s);
        int res = 0;
        for (int i = 0; i < 8; i++) begin
            int l, c, r, p;
            l = (i == 7) ? (wrap ? (v & 1) : 0) : ((v >> (i + 1)) & 1);
            c = (v >> i) & 1;
            r = (i == 0) ? (wrap ? ((v >> 7) & 1) : 0) : ((v >> (i - 1)) & 1);
            p = 4 * l + 2 * c + r;
            if (((int'(rule) >> (7 - p)) & 1) == 1) res = res | (1 << i);
        end
        return res[7:0];
    endfunction

    task automatic build(input logic [7:0] rule, input logic [7:0] seed, input logic [7:0] gens);
        for (int k = 0; k < NI; k++) begin
            logic [7:0] s, nx;
            s = seed;
            nexp[k] = 0;
            for (int g = 0; g <= int'(gens); g++) begin
                exps[k][g] = s;
                nexp[k] = g + 1;
                nx = model_next(s, rule, WRAP_P[k]);
                if (FIX_P[k] && nx == s) break;
                s = nx;
            end
        end
    endtask

    task automatic start(input logic [7:0] rule, input logic [7:0] seed, input logic [7:0] gens);
        int wait_cyc = 0;
        while (!(cfg_ready[0] && cfg_ready[1] && cfg_ready[2]) && wait_cyc < 50) begin
            step();
            wait_cyc++;
        end
        check("cfg_ready_wait", 32'(wait_cyc < 50), 32'd1);
        build(rule, seed, gens);
        cfg_rule  = rule;
        cfg_seed  = seed;
        cfg_gens  = gens;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < NI; k++) check($sformatf("first_valid[%0d]", k), 32'(out_valid[k]), 32'd1);
    endtask

    // mode 0: ready always high; 1: random backpressure; 2: hold ready low
    // for three cycles while generation 1 is on the port.
    task automatic collect(input int mode);
        int idx [NI];
        int hold = 0;
        bit done;
        for (int k = 0; k < NI; k++) begin
            idx[k] = 0;
            got_n[k] = 0;
            got_fin[k] = 8'h00;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            case (mode)
                1:       out_ready = ($urandom_range(0, 3) != 0);
                2:       out_ready = !(idx[0] == 1 && hold < 3);
                default: out_ready = 1'b1;
            endcase
            if (mode == 2 && idx[0] == 1 && hold < 3) begin
                hold++;
                check("hold_valid", 32'(out_valid[0]), 32'd1);
                check("hold_state", 32'(out_state[0]), 32'h01);
                check("hold_gen", 32'(out_gen[0]), 32'd1);
                check("hold_cfg_ready", 32'(cfg_ready[0]), 32'd0);
            end
            for (int k = 0; k < NI; k++) begin
                check($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(out_valid[k]));
                check($sformatf("cfg_ready[%0d]", k), 32'(cfg_ready[k]), 32'(!out_valid[k]));
                if (out_valid[k]) begin
                    if (idx[k] >= nexp[k]) begin
                        check($sformatf("extra_word[%0d]", k), 32'(idx[k]), 32'(nexp[k] - 1));
                    end else begin
                        check($sformatf("state[%0d]g%0d", k, idx[k]), 32'(out_state[k]), 32'(exps[k][idx[k]]));
                        check($sformatf("gen[%0d]g%0d", k, idx[k]), 32'(out_gen[k]), 32'(idx[k]));
                        check($sformatf("last[%0d]g%0d", k, idx[k]), 32'(out_last[k]), 32'(idx[k] == nexp[k] - 1));
                    end
                    if (out_ready) begin
                        got_fin[k] = out_state[k];
                        got_n[k]++;
                        idx[k]++;
                    end
                end
            end
            done = 1'b1;
            for (int k = 0; k < NI; k++) if (idx[k] < nexp[k]) done = 1'b0;
            step();
            if (done) begin
                for (int k = 0; k < NI; k++) check($sformatf("end_valid[%0d]", k), 32'(out_valid[k]), 32'd0);
                return;
            end
        end
        check("collect_timeout", 32'd0, 32'd1);
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{rule: 8'h06, seed: 8'h03, gens: 8'd5, n: '{3, 6, 3}, fin: '{8'h00, 8'h00, 8'h00}};
        vecs[1] = '{rule: 8'h06, seed: 8'h81, gens: 8'd1, n: '{2, 2, 2}, fin: '{8'h80, 8'h80, 8'h00}};
        vecs[2] = '{rule: 8'h5a, seed: 8'hA5, gens: 8'd0, n: '{1, 1, 1}, fin: '{8'hA5, 8'hA5, 8'hA5}};
        vecs[3] = '{rule: 8'h00, seed: 8'hFF, gens: 8'd3, n: '{2, 4, 2}, fin: '{8'h00, 8'h00, 8'h00}};
        vecs[4] = '{rule: 8'hFF, seed: 8'h00, gens: 8'd2, n: '{2, 3, 2}, fin: '{8'hFF, 8'hFF, 8'hFF}};

        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_rule  = 8'h00;
        cfg_seed  = 8'h00;
        cfg_gens  = 8'h00;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_valid[%0d]", k), 32'(out_valid[k]), 32'd0);
            check($sformatf("rst_state[%0d]", k), 32'(out_state[k]), 32'd0);
            check($sformatf("rst_gen[%0d]", k), 32'(out_gen[k]), 32'd0);
            check($sformatf("rst_last[%0d]", k), 32'(out_last[k]), 32'd0);
            check($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 32'd0);
            check($sformatf("rst_cfg_ready[%0d]", k), 32'(cfg_ready[k]), 32'd1);
        end

        foreach (vecs[v]) begin
            start(vecs[v].rule, vecs[v].seed, vecs[v].gens);
            collect(0);
            for (int k = 0; k < NI; k++) begin
                check($sformatf("vec%0d_count[%0d]", v, k), 32'(got_n[k]), 32'(vecs[v].n[k]));
                check($sformatf("vec%0d_final[%0d]", v, k), 32'(got_fin[k]), 32'(vecs[v].fin[k]));
            end
        end

        // Backpressure at generation 1.
        start(8'h06, 8'h03, 8'd5);
        collect(2);

        // Reset while generation 1 is on the port, then a fresh run.
        out_ready = 1'b1;
        start(8'h06, 8'h03, 8'd5);
        check("pre_rst_g0", 32'(out_state[0]), 32'h03);
        step();
        check("pre_rst_g1_state", 32'(out_state[0]), 32'h01);
        check("pre_rst_g1_gen", 32'(out_gen[0]), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("mid_rst_valid[%0d]", k), 32'(out_valid[k]), 32'd0);
            check($sformatf("mid_rst_busy[%0d]", k), 32'(busy[k]), 32'd0);
            check($sformatf("mid_rst_cfg_ready[%0d]", k), 32'(cfg_ready[k]), 32'd1);
            check($sformatf("mid_rst_state[%0d]", k), 32'(out_state[k]), 32'd0);
        end
        start(8'hFF, 8'h00, 8'd0);
        collect(0);
        check("post_rst_count", 32'(got_n[0]), 32'd1);
        check("post_rst_word", 32'(got_fin[0]), 32'h00);

        // cfg_valid held high throughout a gens=0 run, including the final transfer.
        out_ready = 1'b0;
        cfg_rule  = 8'h3c;
        cfg_seed  = 8'hA5;
        cfg_gens  = 8'd0;
        cfg_valid = 1'b1;
        step();
        cfg_seed  = 8'h3C;
        cfg_gens  = 8'd7;
        for (int c = 0; c < 2; c++) begin
            check("busy_cfg_valid", 32'(out_valid[0]), 32'd1);
            check("busy_cfg_state", 32'(out_state[0]), 32'hA5);
            check("busy_cfg_gen", 32'(out_gen[0]), 32'd0);
            check("busy_cfg_last", 32'(out_last[0]), 32'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("final_xfer_idle", 32'(out_valid[0]), 32'd0);
        check("final_xfer_ready", 32'(cfg_ready[0]), 32'd1);
        step();
        check("no_reaccept", 32'(out_valid[0]), 32'd0);

        // Random runs under random backpressure.
        for (int t = 0; t < 25; t++) begin
            logic [7:0] r, s, g;
            r = 8'($urandom);
            s = 8'($urandom);
            g = 8'($urandom_range(0, 12));
            start(r, s, g);
            collect(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
